// File: rtl/axis_seq_pkg.sv
// Shared definitions for the input-pipe sequencer: state codes, stream indices and the beat-count
// type used by the per-stream gate counters.
package axis_seq_pkg;

  localparam int unsigned BITS_BEATS_DEF = 20;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StNext  = 2'd3;

  localparam int unsigned S_PIX1    = 0;
  localparam int unsigned S_PIX2    = 1;
  localparam int unsigned S_W       = 2;
  localparam int unsigned N_STREAMS = 3;

  // One bit wider than the command beat field so beats+1 (config beat) always fits.
  typedef logic [BITS_BEATS_DEF:0] beat_cnt_t;

endpackage

// File: rtl/axis_beat_gate.sv
// Per-stream beat counter: raises the stream gate until the latched target is reached and flags
// any handshake whose tlast disagrees with the counted position.
module axis_beat_gate #(
  parameter int unsigned BITS_BEATS = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                run_i,
  input  logic [BITS_BEATS:0] target_i,
  input  logic                hs_i,
  input  logic                tlast_i,
  output logic                gate_o,
  output logic                complete_o,
  output logic                tlast_err_o
);

  localparam logic [BITS_BEATS:0] BeatOne = {{BITS_BEATS{1'b0}}, 1'b1};

  logic [BITS_BEATS:0] cnt_q, cnt_d;
  logic                below;
  logic                beat;

  assign below      = cnt_q < target_i;
  assign gate_o     = run_i & below;
  assign complete_o = ~below;
  assign beat       = hs_i & gate_o;
  // A zero target never opens the gate, so target-1 is only evaluated when it is meaningful.
  assign tlast_err_o = beat & (tlast_i != (cnt_q == (target_i - BeatOne)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (beat) begin
      cnt_d = cnt_q + BeatOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_input_pipe_seq.sv
// Per-layer sequencer gating the pixels_1/pixels_2/weights streams into the input pipe for N
// iterations. Define AXIS_INPUT_SEQ_TIMEOUT_EN to add the cfg_timeout/err_timeout watchdog.
module axis_input_pipe_seq
  import axis_seq_pkg::*;
#(
  parameter int unsigned BITS_BEATS = BITS_BEATS_DEF,
  parameter int unsigned BITS_ITERS = 8
`ifdef AXIS_INPUT_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned BITS_TIMEOUT = 16
`endif
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_is_max,
  input  logic [BITS_BEATS-1:0]   cmd_beats_im,
  input  logic [BITS_BEATS-1:0]   cmd_beats_w,
  input  logic [BITS_ITERS-1:0]   cmd_iters,
  input  logic                    pix1_hs,
  input  logic                    pix2_hs,
  input  logic                    w_hs,
  input  logic                    pix1_tlast,
  input  logic                    pix2_tlast,
  input  logic                    w_tlast,
  input  logic                    m_hs,
  input  logic                    m_tlast,
`ifdef AXIS_INPUT_SEQ_TIMEOUT_EN
  input  logic [BITS_TIMEOUT-1:0] cfg_timeout,
  output logic                    err_timeout,
`endif
  output logic                    gate_pix1,
  output logic                    gate_pix2,
  output logic                    gate_w,
  output logic                    busy,
  output logic                    done,
  output logic                    err_tlast
);

  localparam logic [BITS_BEATS:0]   BeatOne = {{BITS_BEATS{1'b0}}, 1'b1};
  localparam logic [BITS_ITERS-1:0] IterOne = {{(BITS_ITERS-1){1'b0}}, 1'b1};

  logic [1:0]                          state_q, state_d;
  logic [N_STREAMS-1:0][BITS_BEATS:0]  tgt_q, tgt_d;
  logic [BITS_ITERS-1:0]               iters_q, iters_d, iter_q, iter_d, iter_inc;
  logic                                seen_q, seen_d, err_q, err_d;
  logic [N_STREAMS-1:0]                hs, tlast, gate, cmpl, terr;
  logic                                accept, run, clear, mlast, timeout_hit;

  assign hs[S_PIX1]    = pix1_hs;
  assign hs[S_PIX2]    = pix2_hs;
  assign hs[S_W]       = w_hs;
  assign tlast[S_PIX1] = pix1_tlast;
  assign tlast[S_PIX2] = pix2_tlast;
  assign tlast[S_W]    = w_tlast;

  assign accept   = cmd_valid & (state_q == StIdle);
  assign run      = state_q == StRun;
  assign clear    = accept | (state_q == StNext);
  assign mlast    = m_hs & m_tlast;
  assign iter_inc = iter_q + IterOne;

  for (genvar i = 0; i < N_STREAMS; i++) begin : g_gate
    axis_beat_gate #(
      .BITS_BEATS(BITS_BEATS)
    ) u_gate (
      .clk_i      (aclk),
      .rst_ni     (aresetn),
      .clear_i    (clear),
      .run_i      (run),
      .target_i   (tgt_q[i]),
      .hs_i       (hs[i]),
      .tlast_i    (tlast[i]),
      .gate_o     (gate[i]),
      .complete_o (cmpl[i]),
      .tlast_err_o(terr[i])
    );
  end

  assign gate_pix1 = gate[S_PIX1];
  assign gate_pix2 = gate[S_PIX2];
  assign gate_w    = gate[S_W];
  assign cmd_ready = state_q == StIdle;
  assign busy      = state_q != StIdle;
  assign done      = (state_q == StNext) & (iter_inc == iters_q);
  assign err_tlast = err_q;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    iters_d = iters_q;
    iter_d  = iter_q;
    seen_d  = seen_q;
    err_d   = err_q | (|terr);
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          tgt_d[S_PIX1] = {1'b0, cmd_beats_im} + BeatOne;
          tgt_d[S_PIX2] = cmd_is_max ? {1'b0, cmd_beats_im} : '0;
          tgt_d[S_W]    = {1'b0, cmd_beats_w};
          iters_d       = (cmd_iters == '0) ? IterOne : cmd_iters;
          iter_d        = '0;
          seen_d        = 1'b0;
          err_d         = 1'b0;
          state_d       = StRun;
        end
      end
      StRun: begin
        if (mlast) seen_d = 1'b1;
        if (&cmpl) state_d = StDrain;
      end
      StDrain: begin
        if (seen_q | mlast) state_d = StNext;
      end
      StNext: begin
        seen_d  = 1'b0;
        iter_d  = iter_inc;
        state_d = (iter_inc == iters_q) ? StIdle : StRun;
      end
      default: state_d = StIdle;
    endcase
    if (timeout_hit) state_d = StIdle;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      tgt_q   <= '0;
      iters_q <= '0;
      iter_q  <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      iters_q <= iters_d;
      iter_q  <= iter_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

`ifdef AXIS_INPUT_SEQ_TIMEOUT_EN
  localparam logic [BITS_TIMEOUT-1:0] WdOne = {{(BITS_TIMEOUT-1){1'b0}}, 1'b1};

  logic [BITS_TIMEOUT-1:0] wd_q, wd_d, wd_inc;
  logic                    wd_active, wd_armed, err_to_q, err_to_d;

  // No gate masking is needed on expiry: a timeout cycle by definition carries no handshake.
  assign wd_active   = (|hs) | m_hs;
  assign wd_armed    = (state_q == StRun) | (state_q == StDrain);
  assign wd_inc      = wd_q + WdOne;
  assign timeout_hit = wd_armed & ~wd_active & (wd_inc == cfg_timeout);
  assign err_timeout = err_to_q;

  always_comb begin
    wd_d     = wd_inc;
    err_to_d = err_to_q;
    if (!wd_armed || wd_active || timeout_hit) wd_d = '0;
    if (timeout_hit) err_to_d = 1'b1;
    if (accept) err_to_d = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_q     <= '0;
      err_to_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      err_to_q <= err_to_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
